// File: rtl/qstage_ctrl_dispatch.sv
// qstage_ctrl_dispatch: control-write dispatcher for the quadtree stage tables.
//
// Table-write commands arrive through a valid/ready handshake and wait in a
// small FIFO. Each command is replayed as cmd_len_i+1 single-cycle write beats
// to one partition (one-hot enable) or to all partitions (broadcast). The
// address auto-increments on every beat, and the data word optionally does
// too. Back-to-back commands run with no idle cycle between them.
//
// Ports:
//   clk_i        clock
//   rst_n_i      synchronous active-low reset
//   cmd_valid_i  command valid
//   cmd_ready_o  FIFO can accept (registered; independent of cmd_valid_i)
//   cmd_addr_i   start address
//   cmd_data_i   first data word
//   cmd_sel_i    target part (ignored when cmd_bcast_i is high)
//   cmd_bcast_i  write all parts
//   cmd_len_i    burst length minus one
//   cmd_inc_i    increment data by one on each beat
//   wr_addr_o    table write address
//   wr_data_o    table write data
//   wr_en_o      per-part write enable
//   busy_o       FIFO non-empty or burst in progress
//   done_o       one-cycle pulse on a command's last write beat
//   err_o        sticky invalid-select flag (cleared only by reset)
module qstage_ctrl_dispatch #(
    parameter int unsigned A_WIDTH    = 4,
    parameter int unsigned D_WIDTH    = 32,
    parameter int unsigned PARTS_CNT  = 4,
    parameter int unsigned SEL_WIDTH  = ($clog2(PARTS_CNT) > 0 ? $clog2(PARTS_CNT) : 1),
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [A_WIDTH-1:0]   cmd_addr_i,
    input  logic [D_WIDTH-1:0]   cmd_data_i,
    input  logic [SEL_WIDTH-1:0] cmd_sel_i,
    input  logic                 cmd_bcast_i,
    input  logic [A_WIDTH-1:0]   cmd_len_i,
    input  logic                 cmd_inc_i,
    output logic [A_WIDTH-1:0]   wr_addr_o,
    output logic [D_WIDTH-1:0]   wr_data_o,
    output logic [PARTS_CNT-1:0] wr_en_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);

    localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
    // One extra bit so PARTS_CNT itself is representable for the range check.
    localparam int unsigned SelCmpW = SEL_WIDTH + 1;
    localparam logic [SelCmpW-1:0] PartsLimit = SelCmpW'(PARTS_CNT);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [A_WIDTH-1:0]   fifo_addr_q  [FIFO_DEPTH];
    logic [D_WIDTH-1:0]   fifo_data_q  [FIFO_DEPTH];
    logic [SEL_WIDTH-1:0] fifo_sel_q   [FIFO_DEPTH];
    logic                 fifo_bcast_q [FIFO_DEPTH];
    logic [A_WIDTH-1:0]   fifo_len_q   [FIFO_DEPTH];
    logic                 fifo_inc_q   [FIFO_DEPTH];

    // Pointers carry a wrap bit so full and empty are distinguishable.
    logic [PtrW:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW:0] rd_ptr_q, rd_ptr_d;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                        (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign push       = cmd_valid_i && !fifo_full;

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q[PtrW-1:0]]  <= cmd_addr_i;
            fifo_data_q[wr_ptr_q[PtrW-1:0]]  <= cmd_data_i;
            fifo_sel_q[wr_ptr_q[PtrW-1:0]]   <= cmd_sel_i;
            fifo_bcast_q[wr_ptr_q[PtrW-1:0]] <= cmd_bcast_i;
            fifo_len_q[wr_ptr_q[PtrW-1:0]]   <= cmd_len_i;
            fifo_inc_q[wr_ptr_q[PtrW-1:0]]   <= cmd_inc_i;
        end
    end

    // Head-of-queue view; only consumed when the FIFO is non-empty.
    logic [A_WIDTH-1:0]   head_addr;
    logic [D_WIDTH-1:0]   head_data;
    logic [SEL_WIDTH-1:0] head_sel;
    logic                 head_bcast;
    logic [A_WIDTH-1:0]   head_len;
    logic                 head_inc;
    logic                 head_ok;
    logic [PARTS_CNT-1:0] head_mask;

    assign head_addr  = fifo_addr_q[rd_ptr_q[PtrW-1:0]];
    assign head_data  = fifo_data_q[rd_ptr_q[PtrW-1:0]];
    assign head_sel   = fifo_sel_q[rd_ptr_q[PtrW-1:0]];
    assign head_bcast = fifo_bcast_q[rd_ptr_q[PtrW-1:0]];
    assign head_len   = fifo_len_q[rd_ptr_q[PtrW-1:0]];
    assign head_inc   = fifo_inc_q[rd_ptr_q[PtrW-1:0]];

    // A select past the last part can only happen for non-power-of-2 counts.
    assign head_ok = head_bcast || ({1'b0, head_sel} < PartsLimit);

    always_comb begin
        head_mask = '0;
        for (int unsigned i = 0; i < PARTS_CNT; i++) begin
            head_mask[i] = head_bcast || ({1'b0, head_sel} == SelCmpW'(i));
        end
    end

    // ------------------------------------------------------------------
    // Dispatch FSM and working registers
    // ------------------------------------------------------------------
    state_e               state_q, state_d;
    logic [A_WIDTH-1:0]   cur_addr_q, cur_addr_d;
    logic [D_WIDTH-1:0]   cur_data_q, cur_data_d;
    logic [PARTS_CNT-1:0] cur_mask_q, cur_mask_d;
    logic                 cur_inc_q, cur_inc_d;
    logic [A_WIDTH-1:0]   remaining_q, remaining_d;
    logic                 err_q, err_d;

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        cur_data_d  = cur_data_q;
        cur_mask_d  = cur_mask_q;
        cur_inc_d   = cur_inc_q;
        remaining_d = remaining_q;
        err_d       = err_q;
        pop         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                end
            end
            StRun: begin
                if (remaining_q != '0) begin
                    cur_addr_d  = cur_addr_q + A_WIDTH'(1);
                    cur_data_d  = cur_data_q + D_WIDTH'(cur_inc_q);
                    remaining_d = remaining_q - A_WIDTH'(1);
                end else if (!fifo_empty) begin
                    // Last beat: chain straight into the next command.
                    pop = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (pop) begin
            if (head_ok) begin
                state_d     = StRun;
                cur_addr_d  = head_addr;
                cur_data_d  = head_data;
                cur_mask_d  = head_mask;
                cur_inc_d   = head_inc;
                remaining_d = head_len;
            end else begin
                // Invalid select: drop the command, flag it, no write.
                state_d = StIdle;
                err_d   = 1'b1;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + (PtrW + 1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (PtrW + 1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cur_addr_q  <= '0;
            cur_data_q  <= '0;
            cur_mask_q  <= '0;
            cur_inc_q   <= 1'b0;
            remaining_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cur_addr_q  <= cur_addr_d;
            cur_data_q  <= cur_data_d;
            cur_mask_q  <= cur_mask_d;
            cur_inc_q   <= cur_inc_d;
            remaining_q <= remaining_d;
            err_q       <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decodes of registered state only
    // ------------------------------------------------------------------
    assign cmd_ready_o = !fifo_full;
    assign wr_addr_o   = cur_addr_q;
    assign wr_data_o   = cur_data_q;
    assign wr_en_o     = (state_q == StRun) ? cur_mask_q : '0;
    assign done_o      = (state_q == StRun) && (remaining_q == '0);
    assign busy_o      = (state_q == StRun) || !fifo_empty;
    assign err_o       = err_q;

endmodule

// File: tb/tb_qstage_ctrl_dispatch.sv
module tb_qstage_ctrl_dispatch;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic [1:0]  cmd_sel;
    logic        cmd_bcast;
    logic [3:0]  cmd_len;
    logic        cmd_inc;

    logic        cmd_ready;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_en;
    logic        busy;
    logic        done;
    logic        err;

    logic        cmd_ready3;
    logic [3:0]  wr_addr3;
    logic [31:0] wr_data3;
    logic [2:0]  wr_en3;
    logic        busy3;
    logic        done3;
    logic        err3;

    int n_cmp;
    int n_fail;

    qstage_ctrl_dispatch #(
        .A_WIDTH   (4),
        .D_WIDTH   (32),
        .PARTS_CNT (4),
        .FIFO_DEPTH(4)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_addr_i (cmd_addr),
        .cmd_data_i (cmd_data),
        .cmd_sel_i  (cmd_sel),
        .cmd_bcast_i(cmd_bcast),
        .cmd_len_i  (cmd_len),
        .cmd_inc_i  (cmd_inc),
        .wr_addr_o  (wr_addr),
        .wr_data_o  (wr_data),
        .wr_en_o    (wr_en),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err)
    );

    // Three-part instance shares the command inputs; used for invalid selects.
    qstage_ctrl_dispatch #(
        .A_WIDTH   (4),
        .D_WIDTH   (32),
        .PARTS_CNT (3),
        .FIFO_DEPTH(4)
    ) dut3 (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready3),
        .cmd_addr_i (cmd_addr),
        .cmd_data_i (cmd_data),
        .cmd_sel_i  (cmd_sel),
        .cmd_bcast_i(cmd_bcast),
        .cmd_len_i  (cmd_len),
        .cmd_inc_i  (cmd_inc),
        .wr_addr_o  (wr_addr3),
        .wr_data_o  (wr_data3),
        .wr_en_o    (wr_en3),
        .busy_o     (busy3),
        .done_o     (done3),
        .err_o      (err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one command and hold it until accepted; returns 1 time unit after
    // the handshake edge with cmd_valid low.
    task automatic push(input logic [3:0] a, input logic [31:0] d, input logic [1:0] s,
                        input logic b, input logic [3:0] l, input logic inc);
        int guard;
        logic rdy;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_sel   = s;
        cmd_bcast = b;
        cmd_len   = l;
        cmd_inc   = inc;
        cmd_valid = 1'b1;
        guard = 0;
        rdy = cmd_ready;
        while (!rdy && guard < 100) begin
            step();
            rdy = cmd_ready;
            guard++;
        end
        step();
        cmd_valid = 1'b0;
        n_cmp++;
        if (!rdy) begin
            n_fail++;
            $display("FAIL push_accept: ready=%b required 1", rdy);
        end
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        cmd_valid = 1'b1;
        cmd_addr  = 4'hF;
        cmd_data  = 32'h1234_5678;
        cmd_sel   = 2'd1;
        cmd_bcast = 1'b0;
        cmd_len   = 4'd0;
        cmd_inc   = 1'b0;
        rst_n     = 1'b0;
        step();
        step();
        // cmd_valid held high during reset must be ignored.
        n_cmp++;
        if ({wr_en, busy, done, err, cmd_ready, wr_addr, wr_data} !== {4'b0, 4'b0001, 4'h0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_outputs: en=%b busy=%b done=%b err=%b rdy=%b addr=%h data=%h required all 0, rdy=1",
                     wr_en, busy, done, err, cmd_ready, wr_addr, wr_data);
        end
        cmd_valid = 1'b0;
        rst_n = 1'b1;
        step();
        n_cmp++;
        if ({wr_en, busy, cmd_ready} !== {4'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_release: en=%b busy=%b rdy=%b required 0000/0/1", wr_en, busy, cmd_ready);
        end
    endtask

    task automatic test_single();
        do_reset();
        push(4'd5, 32'hA5, 2'd2, 1'b0, 4'd0, 1'b0);
        n_cmp++;
        if ({wr_en, busy} !== {4'b0000, 1'b1}) begin
            n_fail++;
            $display("FAIL single_queued: en=%b busy=%b required 0000/1", wr_en, busy);
        end
        step();
        n_cmp++;
        if ({wr_en, wr_addr, wr_data, done} !== {4'b0100, 4'd5, 32'hA5, 1'b1}) begin
            n_fail++;
            $display("FAIL single_beat: en=%b addr=%0d data=%h done=%b required 0100/5/a5/1",
                     wr_en, wr_addr, wr_data, done);
        end
        step();
        n_cmp++;
        if ({wr_en, done, busy} !== {4'b0000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL single_after: en=%b done=%b busy=%b required 0000/0/0", wr_en, done, busy);
        end
    endtask

    task automatic test_bcast_burst();
        logic [3:0] exp_addr;
        do_reset();
        push(4'd14, 32'd10, 2'd0, 1'b1, 4'd3, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step();
            exp_addr = 4'd14 + 4'(k);
            n_cmp++;
            if ({wr_en, wr_addr, wr_data, done} !== {4'b1111, exp_addr, 32'(10 + k), (k == 3)}) begin
                n_fail++;
                $display("FAIL bcast_beat%0d: en=%b addr=%0d data=%0d done=%b required 1111/%0d/%0d/%b",
                         k, wr_en, wr_addr, wr_data, done, exp_addr, 10 + k, (k == 3));
            end
        end
        step();
        n_cmp++;
        if ({wr_en, done} !== {4'b0000, 1'b0}) begin
            n_fail++;
            $display("FAIL bcast_after: en=%b done=%b required 0000/0", wr_en, done);
        end
    endtask

    task automatic test_back_to_back();
        int accepted;
        int first_full_acc;
        int pguard;
        logic rdy;
        int b;
        int mguard;
        int c;
        int k;
        logic [3:0]  e_en;
        logic [3:0]  e_addr;
        logic [31:0] e_data;
        do_reset();
        accepted = 0;
        first_full_acc = -1;
        fork
            begin
                pguard = 0;
                cmd_addr  = 4'd0;
                cmd_data  = 32'h0;
                cmd_sel   = 2'd0;
                cmd_bcast = 1'b0;
                cmd_len   = 4'd7;
                cmd_inc   = 1'b1;
                cmd_valid = 1'b1;
                while (accepted < 6 && pguard < 300) begin
                    rdy = cmd_ready;
                    if (!rdy && first_full_acc < 0) first_full_acc = accepted;
                    step();
                    pguard++;
                    if (rdy) begin
                        accepted++;
                        cmd_addr = 4'(accepted * 2);
                        cmd_data = 32'(accepted) << 8;
                        cmd_sel  = 2'(accepted % 4);
                    end
                end
                cmd_valid = 1'b0;
            end
            begin
                mguard = 0;
                while (wr_en === 4'b0 && mguard < 50) begin
                    step();
                    mguard++;
                end
                for (b = 0; b < 48; b++) begin
                    c = b / 8;
                    k = b % 8;
                    e_en   = 4'(1 << (c % 4));
                    e_addr = 4'(c * 2 + k);
                    e_data = (32'(c) << 8) + 32'(k);
                    n_cmp++;
                    if ({wr_en, wr_addr, wr_data, done} !== {e_en, e_addr, e_data, (k == 7)}) begin
                        n_fail++;
                        $display("FAIL b2b_beat%0d: en=%b addr=%0d data=%h done=%b required %b/%0d/%h/%b",
                                 b, wr_en, wr_addr, wr_data, done, e_en, e_addr, e_data, (k == 7));
                    end
                    step();
                end
                n_cmp++;
                if (wr_en !== 4'b0) begin
                    n_fail++;
                    $display("FAIL b2b_after: en=%b required 0000", wr_en);
                end
            end
        join
        n_cmp++;
        if (accepted !== 6) begin
            n_fail++;
            $display("FAIL b2b_accepted: got %0d required 6", accepted);
        end
        // Ready drops after cmd0 is popped and four more fill the FIFO.
        n_cmp++;
        if (first_full_acc !== 5) begin
            n_fail++;
            $display("FAIL b2b_full_point: accepted=%0d when ready fell, required 5", first_full_acc);
        end
    endtask

    task automatic test_invalid_sel();
        int writes;
        do_reset();
        push(4'd2, 32'h11, 2'd3, 1'b0, 4'd0, 1'b0);
        push(4'd7, 32'h33, 2'd1, 1'b0, 4'd0, 1'b0);
        n_cmp++;
        if ({err3, wr_en3} !== {1'b1, 3'b000}) begin
            n_fail++;
            $display("FAIL inv_dropped: err=%b en=%b required 1/000", err3, wr_en3);
        end
        writes = 0;
        step();
        n_cmp++;
        if ({wr_en3, wr_addr3, wr_data3, done3} !== {3'b010, 4'd7, 32'h33, 1'b1}) begin
            n_fail++;
            $display("FAIL inv_next_beat: en=%b addr=%0d data=%h done=%b required 010/7/33/1",
                     wr_en3, wr_addr3, wr_data3, done3);
        end
        for (int i = 0; i < 6; i++) begin
            if (wr_en3 !== 3'b000) writes++;
            step();
        end
        n_cmp++;
        if ({writes, err3} !== {32'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL inv_sticky: writes=%0d err=%b required 1/1", writes, err3);
        end
        n_cmp++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL inv_pow2_no_err: err=%b required 0", err);
        end
    endtask

    task automatic test_mid_reset();
        int writes;
        do_reset();
        push(4'd3, 32'h50, 2'd0, 1'b0, 4'd7, 1'b1);
        push(4'd8, 32'h60, 2'd1, 1'b0, 4'd7, 1'b1);
        push(4'd9, 32'h70, 2'd2, 1'b0, 4'd7, 1'b1);
        n_cmp++;
        if ({wr_en, wr_addr, wr_data} !== {4'b0001, 4'd4, 32'h51}) begin
            n_fail++;
            $display("FAIL midrst_beat2: en=%b addr=%0d data=%h required 0001/4/51", wr_en, wr_addr, wr_data);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_cmp++;
        if ({wr_en, busy, err, done, cmd_ready} !== {4'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL midrst_state: en=%b busy=%b err=%b done=%b rdy=%b required 0000/0/0/0/1",
                     wr_en, busy, err, done, cmd_ready);
        end
        writes = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (wr_en !== 4'b0 || busy !== 1'b0) writes++;
        end
        n_cmp++;
        if (writes !== 0) begin
            n_fail++;
            $display("FAIL midrst_quiet: %0d active cycles required 0", writes);
        end
    endtask

    task automatic test_data_wrap();
        logic [3:0]  e_addr [5];
        logic [31:0] e_data [5];
        logic        e_done [5];
        e_addr = '{4'd2, 4'd3, 4'd4, 4'd9, 4'd10};
        e_data = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
        e_done = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        push(4'd2, 32'hFFFF_FFFF, 2'd0, 1'b0, 4'd2, 1'b0);
        push(4'd9, 32'hFFFF_FFFF, 2'd0, 1'b0, 4'd1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if ({wr_en, wr_addr, wr_data, done} !== {4'b0001, e_addr[k], e_data[k], e_done[k]}) begin
                n_fail++;
                $display("FAIL wrap_beat%0d: en=%b addr=%0d data=%h done=%b required 0001/%0d/%h/%b",
                         k, wr_en, wr_addr, wr_data, done, e_addr[k], e_data[k], e_done[k]);
            end
            step();
        end
        n_cmp++;
        if ({wr_en, busy} !== {4'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL wrap_after: en=%b busy=%b required 0000/0", wr_en, busy);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr = '0;
        cmd_data = '0;
        cmd_sel = '0;
        cmd_bcast = 1'b0;
        cmd_len = '0;
        cmd_inc = 1'b0;
        #1;
        test_reset();
        test_single();
        test_bcast_burst();
        test_back_to_back();
        test_invalid_sel();
        test_mid_reset();
        test_data_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
